// File: rtl/time_counter.sv
// BCD wall-clock counter (hh:mm:ss) advanced by a once-per-second tick, with hold and a validated time-load handshake.
// Optional HOUR12_EN maps the displayed hour to 12h format and drives pm; internal time stays 24h.
module time_counter #(
  parameter logic [7:0] INIT_HOUR = 8'h00,
  parameter logic [7:0] INIT_MIN  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec,
  input  logic       hold,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_hour,
  input  logic [7:0] load_min,
  output logic       load_err,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       pm,
  output logic [1:0] dbg_state
);

  // Handshake: a load transfers at a rising edge when load_valid && load_ready.
  // load_ready is low only during the single LOAD commit cycle.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] hour_q, min_q, sec_q;
  logic [7:0] hour_d, min_d, sec_d;
  logic       min_pulse_q, hour_pulse_q, day_pulse_q, load_err_q, load_ready_q;
  logic       sec_wrap, min_wrap, hour_wrap, load_ok;

  always_comb begin
    sec_wrap  = (sec_q == 8'h59);
    min_wrap  = (min_q == 8'h59);
    hour_wrap = (hour_q == 8'h23);
    sec_d  = (sec_q[3:0] == 4'd9)  ? {sec_q[7:4] + 4'd1, 4'd0}  : {sec_q[7:4], sec_q[3:0] + 4'd1};
    min_d  = (min_q[3:0] == 4'd9)  ? {min_q[7:4] + 4'd1, 4'd0}  : {min_q[7:4], min_q[3:0] + 4'd1};
    hour_d = (hour_q[3:0] == 4'd9) ? {hour_q[7:4] + 4'd1, 4'd0} : {hour_q[7:4], hour_q[3:0] + 4'd1};
    // With valid units nibbles, a plain compare bounds the tens nibble too.
    load_ok = (load_hour[3:0] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
              (load_hour <= 8'h23) && (load_min <= 8'h59);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      hour_q       <= INIT_HOUR;
      min_q        <= INIT_MIN;
      sec_q        <= 8'h00;
      min_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      day_pulse_q  <= 1'b0;
      load_err_q   <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      min_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      day_pulse_q  <= 1'b0;
      load_err_q   <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          state_q      <= hold ? ST_HOLD : ST_RUN;
          load_ready_q <= 1'b1;
        end
        default: begin
          if (load_valid) begin
            state_q      <= ST_LOAD;
            load_ready_q <= 1'b0;
            if (load_ok) begin
              hour_q <= load_hour;
              min_q  <= load_min;
              sec_q  <= 8'h00;
            end else begin
              load_err_q <= 1'b1;
            end
          end else if (state_q == ST_HOLD) begin
            if (!hold) state_q <= ST_RUN;
          end else if (hold) begin
            state_q <= ST_HOLD;
          end else if (one_sec) begin
            sec_q <= sec_wrap ? 8'h00 : sec_d;
            if (sec_wrap) begin
              min_pulse_q <= 1'b1;
              min_q       <= min_wrap ? 8'h00 : min_d;
              if (min_wrap) begin
                hour_pulse_q <= 1'b1;
                hour_q       <= hour_wrap ? 8'h00 : hour_d;
                day_pulse_q  <= hour_wrap;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef HOUR12_EN
  always_comb begin
    pm = (hour_q >= 8'h12);
    case (hour_q)
      8'h00:   hour_bcd = 8'h12;
      8'h13:   hour_bcd = 8'h01;
      8'h14:   hour_bcd = 8'h02;
      8'h15:   hour_bcd = 8'h03;
      8'h16:   hour_bcd = 8'h04;
      8'h17:   hour_bcd = 8'h05;
      8'h18:   hour_bcd = 8'h06;
      8'h19:   hour_bcd = 8'h07;
      8'h20:   hour_bcd = 8'h08;
      8'h21:   hour_bcd = 8'h09;
      8'h22:   hour_bcd = 8'h10;
      8'h23:   hour_bcd = 8'h11;
      default: hour_bcd = hour_q;
    endcase
  end
`else
  assign hour_bcd = hour_q;
  assign pm       = 1'b0;
`endif

  assign min_bcd    = min_q;
  assign sec_bcd    = sec_q;
  assign min_pulse  = min_pulse_q;
  assign hour_pulse = hour_pulse_q;
  assign day_pulse  = day_pulse_q;
  assign load_err   = load_err_q;
  assign load_ready = load_ready_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: reference model keeps time as seconds-of-day and compares every output each checked cycle.
// Build with +define+HOUR12_EN to also exercise the 12h display mapping.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       reset, one_sec, hold, load_valid;
  logic [7:0] load_hour, load_min;
  logic       load_ready, load_err, min_pulse, hour_pulse, day_pulse, pm;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] dbg_state;

  time_counter #(.INIT_HOUR(8'h23), .INIT_MIN(8'h59)) dut (
    .clk(clk), .reset(reset), .one_sec(one_sec), .hold(hold),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_hour(load_hour), .load_min(load_min), .load_err(load_err),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .min_pulse(min_pulse), .hour_pulse(hour_pulse), .day_pulse(day_pulse),
    .pm(pm), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_secs;
  bit m_busy, m_frozen;
  bit e_minp, e_hourp, e_dayp, e_err, e_ready;
  logic [29:0] exp_q[$];

  wire [29:0] obs = {hour_bcd, min_bcd, sec_bcd, min_pulse, hour_pulse, day_pulse, load_err, load_ready, pm};

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit load_is_ok(input logic [7:0] lh, input logic [7:0] lm);
    if (lh[7:4] > 4'd9 || lh[3:0] > 4'd9 || lm[7:4] > 4'd9 || lm[3:0] > 4'd9) return 1'b0;
    return (from_bcd(lh) <= 23) && (from_bcd(lm) <= 59);
  endfunction

  function automatic logic [29:0] exp_vec();
    int h, d;
    bit p;
    h = m_secs / 3600;
    d = h;
    p = 1'b0;
`ifdef HOUR12_EN
    d = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
    p = (h >= 12);
`endif
    return {to_bcd(d), to_bcd((m_secs / 60) % 60), to_bcd(m_secs % 60),
            e_minp, e_hourp, e_dayp, e_err, e_ready, p};
  endfunction

  task automatic model_reset();
    m_secs = 23 * 3600 + 59 * 60;
    m_busy = 1'b0; m_frozen = 1'b0;
    e_minp = 1'b0; e_hourp = 1'b0; e_dayp = 1'b0; e_err = 1'b0; e_ready = 1'b1;
    exp_q.push_back(exp_vec());
  endtask

  // Drives one cycle of inputs, advances the model at the edge, returns 1 time unit after it.
  task automatic step(input bit t, input bit h, input bit lv, input logic [7:0] lh, input logic [7:0] lm);
    one_sec = t; hold = h; load_valid = lv; load_hour = lh; load_min = lm;
    @(posedge clk);
    e_minp = 1'b0; e_hourp = 1'b0; e_dayp = 1'b0; e_err = 1'b0;
    if (m_busy) begin
      m_busy = 1'b0;
      m_frozen = h;
    end else if (lv) begin
      m_busy = 1'b1;
      if (load_is_ok(lh, lm)) m_secs = from_bcd(lh) * 3600 + from_bcd(lm) * 60;
      else e_err = 1'b1;
    end else if (m_frozen) begin
      m_frozen = h;
    end else if (h) begin
      m_frozen = 1'b1;
    end else if (t) begin
      m_secs++;
      if (m_secs % 60 == 0) e_minp = 1'b1;
      if (m_secs % 3600 == 0) e_hourp = 1'b1;
      if (m_secs == 86400) begin m_secs = 0; e_dayp = 1'b1; end
    end
    e_ready = !m_busy;
    #1;
    exp_q.push_back(exp_vec());
    if (exp_q.size() > 4) void'(exp_q.pop_front());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    one_sec = 0; hold = 0; load_valid = 0; load_hour = 0; load_min = 0;
    reset = 1'b1;
    #2;
    model_reset();
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, exp_q[$]); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_q[$]); end
  endtask

  task automatic test_day_rollover();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL day_rollover: got %h expected %h", obs, exp_q[$]); end
    idle();
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL day_pulse_clear: got %h expected %h", obs, exp_q[$]); end
  endtask

  task automatic test_count();
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      if (i >= 9) begin
        checks++;
        if (obs !== exp_q[$]) begin errors++; $display("FAIL count_tick%0d: got %h expected %h", i, obs, exp_q[$]); end
      end
    end
    step(1'b0, 1'b0, 1'b1, 8'h09, 8'h59);
    idle();
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      if (i >= 59) begin
        checks++;
        if (obs !== exp_q[$]) begin errors++; $display("FAIL hour_carry_tick%0d: got %h expected %h", i, obs, exp_q[$]); end
      end
    end
    idle();
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL hold_frozen: got %h expected %h", obs, exp_q[$]); end
    idle();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL hold_release_tick: got %h expected %h", obs, exp_q[$]); end
  endtask

  task automatic test_load_tick();
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    idle();
    for (int i = 0; i < 27; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL load_with_tick: got %h expected %h", obs, exp_q[$]); end
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL tick_in_load: got %h expected %h", obs, exp_q[$]); end
  endtask

  task automatic test_load_err();
    logic [7:0] bad_h[3] = '{8'h24, 8'h12, 8'h0A};
    logic [7:0] bad_m[3] = '{8'h00, 8'h5A, 8'h10};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, bad_h[i], bad_m[i]);
      checks++;
      if (obs !== exp_q[$]) begin errors++; $display("FAIL load_err%0d: got %h expected %h", i, obs, exp_q[$]); end
      idle();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, to_bcd(i * 5), to_bcd(i * 11));
      checks++;
      if (obs !== exp_q[$]) begin errors++; $display("FAIL b2b_load%0d: got %h expected %h", i, obs, exp_q[$]); end
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL load_to_hold: got %h expected %h", obs, exp_q[$]); end
    idle();
  endtask

`ifdef HOUR12_EN
  task automatic test_hour12();
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL h12_midnight: got %h expected %h", obs, exp_q[$]); end
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h13, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL h12_1pm: got %h expected %h", obs, exp_q[$]); end
    idle();
    step(1'b0, 1'b0, 1'b1, 8'h11, 8'h59);
    idle();
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL h12_noon: got %h expected %h", obs, exp_q[$]); end
  endtask
`endif

  task automatic test_random();
    bit t, h, lv;
    logic [7:0] lh, lm;
    for (int i = 0; i < 600; i++) begin
      t  = ($urandom_range(0, 3) != 0);
      h  = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 19) == 0);
      lh = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 23)) : 8'($urandom_range(0, 255));
      lm = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) begin
        lv = 1'b1; lh = 8'h23; lm = 8'h59;
      end
      step(t, h, lv, lh, lm);
      checks++;
      if (obs !== exp_q[$]) begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp_q[$]); end
    end
  endtask

  task automatic test_reset_mid_load();
    step(1'b0, 1'b0, 1'b1, 8'h07, 8'h07);
    reset = 1'b1;
    #2;
    model_reset();
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL reset_mid_load: got %h expected %h", obs, exp_q[$]); end
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (obs !== exp_q[$]) begin errors++; $display("FAIL after_reset_tick: got %h expected %h", obs, exp_q[$]); end
  endtask

  initial begin
    test_reset();
    test_day_rollover();
    test_count();
    test_hold();
    test_load_tick();
    test_load_err();
    test_back_to_back();
`ifdef HOUR12_EN
    test_hour12();
`endif
    test_random();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Consumes the once-per-second tick from the timing pulse generator.
- Maintains wall-clock time as BCD hours, minutes and seconds.
- Emits single-cycle minute, hour and day rollover pulses.
- Supports a valid/ready time-load handshake with a hold (freeze) control; sits between the pulse generator and the display driver.

Parameters:
INIT_HOUR, 8'h00, BCD hour loaded on reset (00-23)
INIT_MIN, 8'h00, BCD minute loaded on reset (00-59)

Ports:
clk  input  1  board clock, rising-edge
reset  input  1  asynchronous, active-high
one_sec  input  1  tick, 1 cycle high per second
hold  input  1  1 = ignore ticks (time frozen)
load_valid  input  1  load request
load_ready  output  1  load accept strobe qualifier
load_hour  input  8  BCD hour, 24h format
load_min  input  8  BCD minute
load_err  output  1  1-cycle pulse, rejected load
hour_bcd  output  8  BCD hours
min_bcd  output  8  BCD minutes
sec_bcd  output  8  BCD seconds
min_pulse  output  1  1-cycle, seconds wrapped 59->00
hour_pulse  output  1  1-cycle, minutes wrapped 59->00
day_pulse  output  1  1-cycle, 23:59:59->00:00:00
pm  output  1  PM flag (see Optional Feature)

Behaviour:
- Reset (async, active-high) forces the following, independent of clk:
  - state RUN.
  - Internal hour = INIT_HOUR, min = INIT_MIN, sec = 00.
  - All pulses 0, load_err 0, load_ready 1.
- Reset asserted mid-load aborts the load; reset values win.
- Internal time is always 24h BCD. Each nibble is in 0-9; the tens nibble range is per field.
- States:
  - RUN: a tick with one_sec=1 at a rising edge advances sec. Outputs show the new value the cycle after the tick edge (1-cycle latency).
  - HOLD: entered from RUN when hold=1; returns to RUN when hold=0. Ticks are ignored and dropped, not queued.
  - LOAD: a 1-cycle commit state. Next state is HOLD if hold=1, else RUN. A tick during LOAD is dropped.
- Counting, BCD per digit:
  - sec units 9->0 carries into the tens digit.
  - sec 59->00 increments min and pulses min_pulse.
  - min 59->00 increments hour and pulses hour_pulse.
  - hour 23->00 pulses day_pulse.
  - Pulses are registered and asserted in the same cycle the wrapped value appears.
  - At 23:59:59 a single tick asserts min_pulse, hour_pulse and day_pulse together for one cycle.
- Load handshake:
  - Transfer occurs when load_valid & load_ready at a rising edge, in RUN or HOLD.
  - load_ready = 0 while in LOAD, else 1.
  - Validation: hour <= 23, min <= 59, every nibble <= 9.
  - Valid: hour/min take the load values and sec = 00, visible the next cycle. No rollover pulses.
  - Invalid: time is unchanged, load_err pulses 1 cycle, state still passes through LOAD.
- Simultaneous load transfer and tick: the load wins and the tick is dropped.
- load_valid held high across LOAD is accepted again the cycle after, once load_ready returns to 1.
- One tick per second is the operating assumption. Back-to-back tick cycles each advance sec; no tick filtering is performed.

Optional Feature:
- Macro HOUR12_EN.
- Defined:
  - hour_bcd is combinationally mapped from internal hours: 00->12, 01-12 unchanged, 13-23 -> 01-11.
  - pm = 1 when internal hour >= 12.
  - Internal counting, load format (24h), validation and pulses are unchanged.
- Undefined: hour_bcd = internal 24h hours and pm tied 0.

Test Plan:
- Reset with INIT_HOUR=8'h23, INIT_MIN=8'h59, then one tick -> hour/min/sec = 00:00:00 next cycle; min_pulse, hour_pulse and day_pulse all 1 for exactly one cycle.
- Reset defaults, 10 ticks -> sec_bcd=8'h10. Continue to 60 total ticks -> sec 8'h00, min_bcd 8'h01, single min_pulse.
- hold=1, 5 ticks -> time unchanged. hold=0, 1 tick -> sec +1.
- Load hour 8'h12, min 8'h34 at sec 8'h27, with a tick in the same cycle -> 12:34:00 next cycle, load_ready=0 for 1 cycle, tick lost, no pulses.
- Load hour 8'h24 (and separately min 8'h5A) -> load_err 1 cycle, time unchanged.
- With HOUR12_EN: load 8'h00 -> hour_bcd 8'h12, pm 0; load 8'h13 -> 8'h01, pm 1; from 11:59:59 one tick -> 8'h12, pm 1.
